bdi_decompressor: RTL

- Decompression end of the cache-line compression path: accepts one Base-Delta-Immediate (BDI) compressed 256-bit line and its 3-bit encoding, and rebuilds the original 256-bit line.
- Sits between the compressed line store and the requester.
- Two-stage pipeline: stage 1 registers and field-splits the input; stage 2 sign-extends and adds the deltas and holds the result.
- Valid/ready handshake on both sides, with full backpressure.

---
 rtl/bdi_pkg.sv | 57 +++++
 rtl/bdi_expand.sv | 33 +++
 rtl/bdi_decompressor.sv | 87 ++++++++
 3 files changed

// File: rtl/bdi_pkg.sv
// Shared Base-Delta-Immediate definitions: encoding ids, per-encoding field
// geometry and compressed sizes, used by both compressor and decompressor.
package bdi_pkg;

  localparam int LINE_BITS = 256;

  localparam logic [2:0] ENC_ZERO   = 3'd0;
  localparam logic [2:0] ENC_W64D8  = 3'd1;
  localparam logic [2:0] ENC_W64D16 = 3'd2;
  localparam logic [2:0] ENC_W64D32 = 3'd3;
  localparam logic [2:0] ENC_W32D8  = 3'd4;
  localparam logic [2:0] ENC_W32D16 = 3'd5;
  localparam logic [2:0] ENC_W16D8  = 3'd6;
  localparam logic [2:0] ENC_RAW    = 3'd7;

  // Element width; zero and raw lines have no element structure.
  function automatic int enc_w(input int enc);
    case (enc)
      1, 2, 3: return 64;
      4, 5:    return 32;
      6:       return 16;
      default: return 0;
    endcase
  endfunction

  // Base width always equals the element width in this scheme.
  function automatic int enc_b(input int enc);
    return enc_w(enc);
  endfunction

  function automatic int enc_d(input int enc);
    case (enc)
      1, 4, 6: return 8;
      2, 5:    return 16;
      3:       return 32;
      default: return 0;
    endcase
  endfunction

  function automatic int enc_n(input int enc);
    case (enc)
      1, 2, 3: return 4;
      4, 5:    return 8;
      6:       return 16;
      default: return 0;
    endcase
  endfunction

  function automatic int comp_size(input int enc);
    case (enc)
      0:       return 0;
      7:       return LINE_BITS;
      default: return enc_b(enc) + enc_n(enc) * enc_d(enc);
    endcase
  endfunction

endpackage

// File: rtl/bdi_expand.sv
// Combinational BDI expansion: builds every candidate line from the payload
// and selects the one named by the encoding id.
module bdi_expand
  import bdi_pkg::*;
(
  input  logic [2:0]           enc,
  input  logic [LINE_BITS-1:0] payload,
  output logic [LINE_BITS-1:0] line
);

  logic [7:0][LINE_BITS-1:0] cand;

  assign cand[ENC_ZERO] = '0;
  assign cand[ENC_RAW]  = payload;

  for (genvar gi = 1; gi < 7; gi++) begin : g_enc
    localparam int W = enc_w(gi);
    localparam int B = enc_b(gi);
    localparam int D = enc_d(gi);
    localparam int N = enc_n(gi);

    // Each element is a W-bit add, so carries never leak into a neighbour.
    for (genvar ej = 0; ej < N; ej++) begin : g_elem
      assign cand[gi][ej*W +: W] =
        payload[B-1:0] + {{(W-D){payload[B+(ej+1)*D-1]}}, payload[B+ej*D +: D]};
    end
  end

  always_comb begin
    line = cand[enc];
  end

endmodule

// File: rtl/bdi_decompressor.sv
// Two-stage BDI decompressor: stage 1 captures the compressed line, stage 2
// holds the expanded line until the consumer takes it.
module bdi_decompressor
  import bdi_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_enc,
  input  logic [LINE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] out_data,
  output logic [2:0]        out_enc,
  output logic [CNT_W-1:0]  lines_done
);

  logic              s1_valid_reg;
  logic [2:0]        s1_enc_reg;
  logic [LINE_W-1:0] s1_data_reg;
  logic              s2_valid_reg;
  logic [2:0]        s2_enc_reg;
  logic [LINE_W-1:0] s2_data_reg;
  logic [CNT_W-1:0]  lines_done_reg;
  logic [CNT_W-1:0]  lines_done_next;
  logic [LINE_W-1:0] s2_line_next;
  logic              s1_advance;
  logic              in_fire;
  logic              out_fire;

  bdi_expand u_expand (
    .enc     (s1_enc_reg),
    .payload (s1_data_reg),
    .line    (s2_line_next)
  );

  // Outputs are forced quiet while reset is held, even before the first edge.
  assign out_valid  = s2_valid_reg && resetn;
  assign out_data   = resetn ? s2_data_reg : '0;
  assign out_enc    = resetn ? s2_enc_reg : '0;
  assign lines_done = lines_done_reg;

  assign out_fire   = out_valid && out_ready;
  assign s1_advance = !s2_valid_reg || out_ready;
  assign in_ready   = resetn && (!s1_valid_reg || s1_advance);
  assign in_fire    = in_valid && in_ready;

  always_comb begin
    lines_done_next = lines_done_reg;
    if (out_fire && (lines_done_reg != {CNT_W{1'b1}})) begin
      lines_done_next = lines_done_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      s1_valid_reg   <= 1'b0;
      s1_enc_reg     <= '0;
      s1_data_reg    <= '0;
      s2_valid_reg   <= 1'b0;
      s2_enc_reg     <= '0;
      s2_data_reg    <= '0;
      lines_done_reg <= '0;
    end else begin
      if (in_ready) begin
        s1_valid_reg <= in_valid;
        if (in_fire) begin
          s1_enc_reg  <= in_enc;
          s1_data_reg <= in_data;
        end
      end
      if (s1_advance) begin
        s2_valid_reg <= s1_valid_reg;
        if (s1_valid_reg) begin
          s2_enc_reg  <= s1_enc_reg;
          s2_data_reg <= s2_line_next;
        end
      end
      lines_done_reg <= lines_done_next;
    end
  end

endmodule
